ictrl_flit_packer: RTL

- Downstream neighbour of the instruction DMA read channel inside the instruction-controller subsystem.
- Consumes 128-bit DMA read beats (valid/ready with byte strobe) and packs them into 32-bit NoC flits, prefixed by one head flit carrying the destination node mask and payload length.
- Output drives one NoC send lane (send_valid/send_flit/send_ready).
- Lets the kernel multicast a DMA-fetched instruction stream to any subset of the 12 compute nodes without staging it in the ibuffer.

---
 rtl/ictrl_flit_packer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ictrl_flit_packer.sv
// Packs 128-bit DMA read beats into 32-bit NoC flits behind one head flit {4'hA, dest mask, flit count}.
// Latency: head flit the cycle after cfg accept; one LOAD bubble per stream start, then 1 flit/cycle.
// Backpressure: out_ready low freezes the presented flit; in_ready stays low until the current beat drains.
module ictrl_flit_packer #(
    parameter int DATA_WIDTH = 128,
    parameter int FLIT_WIDTH = 32,
    parameter int BEAT_W     = 14,
    parameter int NODE_NUM   = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [NODE_NUM-1:0]     cfg_dest_mask,
    input  logic [BEAT_W-1:0]       cfg_beats,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [DATA_WIDTH/8-1:0] in_strb,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [FLIT_WIDTH-1:0]   out_flit,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done
);
    localparam int LEN_W  = FLIT_WIDTH - 4 - NODE_NUM;
    localparam int NBYTES = DATA_WIDTH / 8;

    typedef enum logic [2:0] {IDLE, HEAD, LOAD, SEND, DONE} state_t;

    state_t                      state_q;
    logic [NODE_NUM-1:0]         mask_q;
    logic [BEAT_W-1:0]           beats_q;
    logic [BEAT_W-1:0]           beat_cnt_q;
    logic [1:0]                  idx_q;
    logic [3:0][FLIT_WIDTH-1:0]  beat_q;
    logic [DATA_WIDTH-1:0]       beat_masked;
    logic [LEN_W-1:0]            len;
    logic                        zero_len;
    logic                        last_beat;
    logic                        fast_load;

    always_comb begin
        beat_masked = '0;
        for (int i = 0; i < NBYTES; i++) begin
            beat_masked[i*8 +: 8] = in_strb[i] ? in_data[i*8 +: 8] : 8'h00;
        end
    end

    assign len       = LEN_W'({beats_q, 2'b00});
    assign zero_len  = (beats_q == '0);
    // Only meaningful in SEND, where beats_q is known to be non-zero.
    assign last_beat = (beat_cnt_q == beats_q - BEAT_W'(1));
    // Next beat can be taken while the final flit of the current one hands off.
    assign fast_load = (state_q == SEND) && out_ready && (idx_q == 2'd3) && !last_beat;

    assign cfg_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign in_ready  = (state_q == LOAD) || fast_load;
    assign out_valid = (state_q == HEAD) || (state_q == SEND);

    always_comb begin
        out_flit = '0;
        out_last = 1'b0;
        if (state_q == HEAD) begin
            out_flit = {4'hA, mask_q, len};
            out_last = zero_len;
        end else if (state_q == SEND) begin
            out_flit = beat_q[idx_q];
            out_last = (idx_q == 2'd3) && last_beat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            beats_q    <= '0;
            beat_cnt_q <= '0;
            idx_q      <= '0;
            beat_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg_valid) begin
                        mask_q     <= cfg_dest_mask;
                        beats_q    <= cfg_beats;
                        beat_cnt_q <= '0;
                        state_q    <= HEAD;
                    end
                end
                HEAD: begin
                    if (out_ready) begin
                        state_q <= zero_len ? DONE : LOAD;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        beat_q  <= beat_masked;
                        idx_q   <= '0;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (idx_q != 2'd3) begin
                            idx_q <= idx_q + 2'd1;
                        end else if (last_beat) begin
                            state_q <= DONE;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
                            if (in_valid) begin
                                beat_q <= beat_masked;
                                idx_q  <= '0;
                            end else begin
                                state_q <= LOAD;
                            end
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule
